// File: rtl/seq_decode_pkg.sv
// Shared types for the decode/sequence control unit.
// Opcode constants, phase-state enum and instruction-class flags.
package seq_decode_pkg;

  localparam logic [5:0] OP_MUL = 6'b011100;
  localparam logic [5:0] OP_MLA = 6'b011101;
  localparam logic [5:0] OP_MLS = 6'b011110;
  localparam logic [5:0] OP_PSH = 6'b101000;
  localparam logic [5:0] OP_POP = 6'b101001;
  localparam logic [5:0] OP_NOP = 6'b111110;
  localparam logic [5:0] OP_STP = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC1,
    ST_EXEC2
  } state_t;

  typedef struct packed {
    logic is_alu;
    logic is_ujmp;
    logic is_jmp;
    logic is_mul;
    logic is_psh;
    logic is_pop;
    logic is_stp;
    logic is_load;
    logic is_store;
  } cls_t;

endpackage

// File: rtl/seq_decode_class.sv
// Combinational instruction classifier: class flags and register fields.
// i_instr -> o_cls, o_rd, o_rs1, o_rs2, o_rls.
module seq_decode_class
  import seq_decode_pkg::*;
#(
  parameter  int RW = 3,
  localparam int IW = 7 + 3 * RW
) (
  input  logic [IW-1:0] i_instr,
  output cls_t          o_cls,
  output logic [RW-1:0] o_rd,
  output logic [RW-1:0] o_rs1,
  output logic [RW-1:0] o_rs2,
  output logic [RW-1:0] o_rls
);

  logic       w_msb;
  logic       w_ls;
  logic [5:0] w_op;

  assign w_msb = i_instr[IW-1];
  assign w_ls  = i_instr[IW-2];
  assign w_op  = i_instr[3*RW+5:3*RW];
  assign o_rd  = i_instr[3*RW-1:2*RW];
  assign o_rs1 = i_instr[2*RW-1:RW];
  assign o_rs2 = i_instr[RW-1:0];
  assign o_rls = i_instr[IW-3 -: RW];

  always_comb begin
    o_cls = '0;
    if (w_msb) begin
      o_cls.is_load  = ~w_ls;
      o_cls.is_store = w_ls;
    end else begin
      casez (w_op)
        6'b0000??:              o_cls.is_ujmp = 1'b1;
        6'b0001??, 6'b0010??:   o_cls.is_jmp  = 1'b1;
        OP_MUL, OP_MLA, OP_MLS: o_cls.is_mul  = 1'b1;
        OP_PSH:                 o_cls.is_psh  = 1'b1;
        OP_POP:                 o_cls.is_pop  = 1'b1;
        OP_STP:                 o_cls.is_stp  = 1'b1;
        OP_NOP:                 o_cls         = '0;
        default:                o_cls.is_alu  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/seq_decode_ctrl.sv
// Decoder plus FETCH/EXEC1/EXEC2 sequencer with fetch handshake and idle.
// clk/rst_n/run/imem_* in; phase, halted, register/RAM/ALU/stack ctrl out.
module seq_decode_ctrl
  import seq_decode_pkg::*;
#(
  parameter  int NREG    = 8,
  parameter  int MUL_LAT = 2,
  localparam int RW      = $clog2(NREG),
  localparam int IW      = 7 + 3 * RW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [IW-1:0]   imem_data,
  input  logic            cond_result,
  output logic [2:0]      phase,
  output logic            halted,
  output logic            pc_count,
  output logic [NREG-1:0] reg_wen,
  output logic [RW-1:0]   s1,
  output logic [RW-1:0]   s2,
  output logic [RW-1:0]   s3,
  output logic            s4,
  output logic            dmem_en,
  output logic            dmem_wren,
  output logic            alu_en,
  output logic            stack_en,
  output logic            stack_rst,
  output logic            stack_rw
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t        r_state;
  logic [IW-1:0] r_instr;
  logic [CW-1:0] r_cnt;

  cls_t          w_cls;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rs1;
  logic [RW-1:0] w_rs2;
  logic [RW-1:0] w_rls;
  logic          w_last;
  logic          w_taken;
  logic          w_exec;
  logic          w_active;

  seq_decode_class #(.RW(RW)) u_class (
    .i_instr (r_instr),
    .o_cls   (w_cls),
    .o_rd    (w_rd),
    .o_rs1   (w_rs1),
    .o_rs2   (w_rs2),
    .o_rls   (w_rls)
  );

  // LOAD/POP finish after one EXEC2 cycle; multiplies wait on the counter.
  assign w_last   = w_cls.is_mul ? (r_cnt == CW'(MUL_LAT - 1)) : 1'b1;
  assign w_taken  = w_cls.is_ujmp | (w_cls.is_jmp & cond_result);
  assign w_exec   = (r_state == ST_EXEC1) || (r_state == ST_EXEC2);
  assign w_active = (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_instr <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_valid) begin
            r_instr <= imem_data;
            r_state <= ST_EXEC1;
          end
        end
        ST_EXEC1: begin
          r_cnt <= '0;
          if (w_cls.is_load | w_cls.is_mul | w_cls.is_pop)
            r_state <= ST_EXEC2;
          else if (w_cls.is_stp)
            r_state <= ST_IDLE;
          else
            r_state <= ST_FETCH;
        end
        ST_EXEC2: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= ST_FETCH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    phase     = 3'b000;
    halted    = 1'b0;
    pc_count  = 1'b0;
    reg_wen   = '0;
    dmem_en   = 1'b0;
    dmem_wren = 1'b0;
    stack_en  = 1'b0;
    stack_rst = 1'b0;
    stack_rw  = 1'b0;
    unique case (r_state)
      ST_IDLE: halted = 1'b1;
      ST_FETCH: begin
        imem_req = 1'b1;
        phase    = 3'b001;
      end
      ST_EXEC1: begin
        phase    = 3'b010;
        pc_count = ~(w_taken | w_cls.is_stp);
        if (w_cls.is_alu) reg_wen = NREG'(1) << w_rd;
        else if (w_taken) reg_wen = NREG'(1);
        dmem_en   = w_cls.is_load | w_cls.is_store;
        dmem_wren = w_cls.is_store;
        stack_en  = w_cls.is_psh;
        stack_rst = w_cls.is_stp;
      end
      ST_EXEC2: begin
        phase    = 3'b100;
        stack_en = w_cls.is_pop;
        stack_rw = w_cls.is_pop;
        if (w_last) begin
          if (w_cls.is_load)
            reg_wen = NREG'(1) << w_rls;
          else if (w_cls.is_mul | w_cls.is_pop)
            reg_wen = NREG'(1) << w_rd;
        end
      end
      default: halted = 1'b1;
    endcase
  end

  always_comb begin
    s1 = '0;
    s2 = '0;
    s3 = '0;
    if (w_exec) begin
      if (w_cls.is_alu | w_cls.is_mul) begin
        s1 = w_rs1;
        s2 = w_rs2;
        s3 = w_rd;
      end else if (w_cls.is_store) begin
        s1 = w_rls;
      end else if (w_cls.is_psh) begin
        s1 = w_rs1;
      end
    end
  end

  assign s4     = ~(w_cls.is_load & w_active);
  assign alu_en = (w_cls.is_load | w_cls.is_store) & w_active;

endmodule

// File: tb/tb_seq_decode_ctrl.sv
// Directed bench for seq_decode_ctrl (NREG=8, MUL_LAT=3).
// Hand-encoded instructions with hand-computed control outputs.
module tb_seq_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        cond_result;
  logic [2:0]  phase;
  logic        halted;
  logic        pc_count;
  logic [7:0]  reg_wen;
  logic [2:0]  s1;
  logic [2:0]  s2;
  logic [2:0]  s3;
  logic        s4;
  logic        dmem_en;
  logic        dmem_wren;
  logic        alu_en;
  logic        stack_en;
  logic        stack_rst;
  logic        stack_rw;

  int n_chk;
  int n_err;

  seq_decode_ctrl #(.NREG(8), .MUL_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .cond_result (cond_result),
    .phase       (phase),
    .halted      (halted),
    .pc_count    (pc_count),
    .reg_wen     (reg_wen),
    .s1          (s1),
    .s2          (s2),
    .s3          (s3),
    .s4          (s4),
    .dmem_en     (dmem_en),
    .dmem_wren   (dmem_wren),
    .alu_en      (alu_en),
    .stack_en    (stack_en),
    .stack_rst   (stack_rst),
    .stack_rw    (stack_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word in FETCH; returns in EXEC1.
  task automatic fetch(input logic [15:0] w);
    chk("in_fetch", 32'(phase), 32'h1);
    imem_valid = 1'b1;
    imem_data  = w;
    tick();
    imem_valid = 1'b0;
    imem_data  = '0;
  endtask

  initial begin
    int req_n;
    int bad;
    n_chk       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    run         = 1'b0;
    imem_valid  = 1'b0;
    imem_data   = '0;
    cond_result = 1'b0;
    tick();
    tick();
    chk("rst_halted", 32'(halted), 32'h1);
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_wen", 32'(reg_wen), 32'h0);
    chk("rst_s4", 32'(s4), 32'h1);
    chk("rst_pc", 32'(pc_count), 32'h0);
    chk("rst_alu_en", 32'(alu_en), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(halted), 32'h1);

    // ALU op 100000, Rd=1 Rs1=3 Rs2=2, valid after 3 wait cycles
    run = 1'b1;
    tick();
    run = 1'b0;
    req_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req) req_n++;
      if (i == 3) begin
        imem_valid = 1'b1;
        imem_data  = 16'h405A;
      end
      tick();
    end
    imem_valid = 1'b0;
    chk("alu_req_cycles", 32'(req_n), 32'd4);
    chk("alu_phase", 32'(phase), 32'h2);
    chk("alu_wen", 32'(reg_wen), 32'h02);
    chk("alu_s1", 32'(s1), 32'd3);
    chk("alu_s2", 32'(s2), 32'd2);
    chk("alu_s3", 32'(s3), 32'd1);
    chk("alu_pc", 32'(pc_count), 32'h1);
    tick();

    // LOAD Rls=5
    fetch(16'hA812);
    chk("ld_dmem_en", 32'(dmem_en), 32'h1);
    chk("ld_wren", 32'(dmem_wren), 32'h0);
    chk("ld_s4", 32'(s4), 32'h0);
    chk("ld_alu_en", 32'(alu_en), 32'h1);
    chk("ld_e1_wen", 32'(reg_wen), 32'h0);
    tick();
    chk("ld_e2_phase", 32'(phase), 32'h4);
    chk("ld_e2_wen", 32'(reg_wen), 32'h20);
    tick();

    // MUL Rd=6 Rs1=2 Rs2=1, three EXEC2 cycles
    fetch(16'h3991);
    chk("mul_e1_wen", 32'(reg_wen), 32'h0);
    chk("mul_s1", 32'(s1), 32'd2);
    chk("mul_s2", 32'(s2), 32'd1);
    chk("mul_s3", 32'(s3), 32'd6);
    tick();
    chk("mul_c1_phase", 32'(phase), 32'h4);
    chk("mul_c1_wen", 32'(reg_wen), 32'h0);
    tick();
    chk("mul_c2_phase", 32'(phase), 32'h4);
    chk("mul_c2_wen", 32'(reg_wen), 32'h0);
    tick();
    chk("mul_c3_phase", 32'(phase), 32'h4);
    chk("mul_c3_wen", 32'(reg_wen), 32'h40);
    tick();

    // JMP taken then not taken
    cond_result = 1'b1;
    fetch(16'h0800);
    chk("jmp_t_wen", 32'(reg_wen), 32'h01);
    chk("jmp_t_pc", 32'(pc_count), 32'h0);
    tick();
    cond_result = 1'b0;
    fetch(16'h0800);
    chk("jmp_n_wen", 32'(reg_wen), 32'h0);
    chk("jmp_n_pc", 32'(pc_count), 32'h1);
    tick();

    // UJMP ignores cond_result
    fetch(16'h0000);
    chk("ujmp_wen", 32'(reg_wen), 32'h01);
    chk("ujmp_pc", 32'(pc_count), 32'h0);
    tick();

    // STORE Rls=4
    fetch(16'hE000);
    chk("st_dmem_en", 32'(dmem_en), 32'h1);
    chk("st_wren", 32'(dmem_wren), 32'h1);
    chk("st_s1", 32'(s1), 32'd4);
    chk("st_wen", 32'(reg_wen), 32'h0);
    tick();
    chk("st_back_fetch", 32'(phase), 32'h1);

    // PSH Rs1=5
    fetch(16'h5028);
    chk("psh_stack_en", 32'(stack_en), 32'h1);
    chk("psh_rw", 32'(stack_rw), 32'h0);
    chk("psh_s1", 32'(s1), 32'd5);
    chk("psh_wen", 32'(reg_wen), 32'h0);
    tick();

    // POP Rd=3
    fetch(16'h52C0);
    chk("pop_e1_stack_en", 32'(stack_en), 32'h0);
    tick();
    chk("pop_e2_stack", 32'({stack_en, stack_rw}), 32'h3);
    chk("pop_e2_wen", 32'(reg_wen), 32'h08);
    tick();

    // STP -> IDLE; stray valid ignored; run restarts
    fetch(16'h7E00);
    chk("stp_stack_rst", 32'(stack_rst), 32'h1);
    chk("stp_pc", 32'(pc_count), 32'h0);
    tick();
    chk("stp_halted", 32'(halted), 32'h1);
    chk("stp_phase", 32'(phase), 32'h0);
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    chk("idle_ignores_valid", 32'(halted), 32'h1);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("restart_phase", 32'(phase), 32'h1);

    // Reset during second MUL EXEC2 cycle
    fetch(16'h3991);
    tick();
    tick();
    chk("mr_c2_phase", 32'(phase), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mr_halted", 32'(halted), 32'h1);
    chk("mr_wen", 32'(reg_wen), 32'h0);
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (reg_wen != 8'h0 || phase != 3'b000) bad++;
      tick();
    end
    chk("mr_no_writeback", 32'(bad), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
